// File: rtl/otter_bus_resp.sv
// OTTER memory/MMIO responder: byte-strobed dual-read RAM plus a GPIO, compare-match
// timer and sticky bus-error block behind a 64-byte MMIO window.
module otter_bus_resp #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE = 32'h1100_0000,
  parameter int          GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_r_data,
  input  logic              dmem_r_en,
  input  logic              dmem_w_en,
  input  logic [3:0]        dmem_w_strb,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_w_data,
  output logic [31:0]       dmem_r_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              intrpt,
  output logic              bus_err
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic {SRC_RAM, SRC_REG} rd_src_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------- address decode ----------------
  logic [AW-1:0] i_idx, d_idx;
  logic          ram_hit, mmio_hit, bad_addr, ram_we, mmio_we;
  logic [3:0]    reg_sel;
  logic          unused_addr_bits;

  assign i_idx    = imem_addr[AW+1:2];
  assign d_idx    = dmem_addr[AW+1:2];
  assign ram_hit  = {1'b0, dmem_addr} < RAM_BYTES;
  assign mmio_hit = !ram_hit && (dmem_addr[31:6] == MMIO_BASE[31:6]);
  assign bad_addr = !ram_hit && !mmio_hit;
  assign ram_we   = !rst && dmem_w_en && ram_hit;
  assign mmio_we  = dmem_w_en && mmio_hit;
  assign reg_sel  = dmem_addr[5:2];
  // Fetch wraps modulo the RAM size, so the upper fetch bits are intentionally ignored.
  assign unused_addr_bits = &{1'b0, imem_addr[31:AW+2], imem_addr[1:0]};

  // ---------------- RAM: one byte-wide array per lane ----------------
  logic [3:0][7:0] i_lane, d_lane;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];
      logic [7:0] i_q_reg;
      logic [7:0] d_q_reg;

      always_ff @(posedge clk) begin
        if (ram_we && dmem_w_strb[gi]) lane_mem[d_idx] <= dmem_w_data[8*gi +: 8];
      end

      // Both read ports sample the array before the write lands (read-before-write).
      always_ff @(posedge clk) begin
        if (rst) i_q_reg <= '0;
        else     i_q_reg <= lane_mem[i_idx];
      end

      always_ff @(posedge clk) begin
        if (dmem_r_en) d_q_reg <= lane_mem[d_idx];
      end

      assign i_lane[gi] = i_q_reg;
      assign d_lane[gi] = d_q_reg;
    end
  endgenerate

  assign imem_r_data = i_lane;

  // ---------------- MMIO / timer / error state ----------------
  logic [GPIO_W-1:0] gpio_s1_reg, gpio_s2_reg;
  logic [GPIO_W-1:0] gpio_out_reg, gpio_out_next;
  logic [31:0]       cnt_reg, cnt_next;
  logic [31:0]       cmp_reg, cmp_next;
  logic              en_reg, en_next;
  logic              pend_reg, pend_next;
  logic              bus_err_reg, bus_err_next;
  logic [31:0]       err_addr_reg, err_addr_next;
  logic [31:0]       gpio_merged;
  logic              tmr_match, pend_clr;
  logic [31:0]       mmio_rd;

  always_comb begin
    gpio_out_next = gpio_out_reg;
    cnt_next      = cnt_reg;
    cmp_next      = cmp_reg;
    en_next       = en_reg;
    pend_next     = pend_reg;
    bus_err_next  = bus_err_reg;
    err_addr_next = err_addr_reg;
    pend_clr      = 1'b0;
    gpio_merged   = lane_merge(32'(gpio_out_reg), dmem_w_data, dmem_w_strb);

    if (mmio_we) begin
      case (reg_sel)
        4'h1: gpio_out_next = gpio_merged[GPIO_W-1:0];
        4'h3: cmp_next      = lane_merge(cmp_reg, dmem_w_data, dmem_w_strb);
        4'h4: if (dmem_w_strb[0]) begin
          en_next  = dmem_w_data[0];
          pend_clr = dmem_w_data[1];
        end
        default: ;
      endcase
    end

    tmr_match = en_reg && (cnt_reg == cmp_reg);
    if (en_reg) cnt_next = tmr_match ? 32'd0 : cnt_reg + 32'd1;

    // A match in the same cycle as a W1C keeps the flag set.
    if (tmr_match)     pend_next = 1'b1;
    else if (pend_clr) pend_next = 1'b0;

    if ((dmem_r_en || dmem_w_en) && bad_addr) begin
      bus_err_next = 1'b1;
      if (!bus_err_reg) err_addr_next = dmem_addr;
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (reg_sel)
      4'h0: mmio_rd = 32'(gpio_s2_reg);
      4'h1: mmio_rd = 32'(gpio_out_reg);
      4'h2: mmio_rd = cnt_reg;
      4'h3: mmio_rd = cmp_reg;
      4'h4: mmio_rd = {30'd0, pend_reg, en_reg};
      4'h5: mmio_rd = err_addr_reg;
      default: mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_s1_reg  <= '0;
      gpio_s2_reg  <= '0;
      gpio_out_reg <= '0;
      cnt_reg      <= '0;
      cmp_reg      <= '0;
      en_reg       <= 1'b0;
      pend_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      gpio_s1_reg  <= gpio_in;
      gpio_s2_reg  <= gpio_s1_reg;
      gpio_out_reg <= gpio_out_next;
      cnt_reg      <= cnt_next;
      cmp_reg      <= cmp_next;
      en_reg       <= en_next;
      pend_reg     <= pend_next;
      bus_err_reg  <= bus_err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  // ---------------- data read return path ----------------
  // Non-RAM reads are resolved into reg_q_reg; RAM reads come straight from the lane registers.
  rd_src_t     rd_src_reg;
  logic [31:0] reg_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_src_reg <= SRC_REG;
      reg_q_reg  <= '0;
    end else if (dmem_r_en) begin
      rd_src_reg <= ram_hit ? SRC_RAM : SRC_REG;
      reg_q_reg  <= mmio_hit ? mmio_rd : 32'hDEAD_BEEF;
    end
  end

  assign dmem_r_data = (rd_src_reg == SRC_RAM) ? d_lane : reg_q_reg;
  assign gpio_out    = gpio_out_reg;
  assign intrpt      = pend_reg && en_reg;
  assign bus_err     = bus_err_reg;

endmodule

// File: doc/otter_bus_resp.md
# otter_bus_resp

Memory and MMIO responder that services the OTTER core's instruction and data ports. It provides a word-addressed, byte-strobed RAM with one-cycle registered reads on both ports. It also provides a small MMIO region with GPIO, a compare-match timer that drives the core's external interrupt input, and sticky bus-error capture. It sits at the top level between `otter_mcu` and the board I/O.

## Interface
Parameters:
- `MEM_WORDS`, 16384 — RAM depth in 32-bit words (64 KiB); must be a power of two.
- `MMIO_BASE`, 32'h1100_0000 — base address of the MMIO window, 64-byte aligned.
- `GPIO_W`, 16 — width of the GPIO input and output.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `imem_addr` in 32 — instruction fetch address.
- `imem_r_data` out 32 — fetched instruction, registered.
- `dmem_r_en` in 1 — data read request.
- `dmem_w_en` in 1 — data write request.
- `dmem_w_strb` in 4 — byte-lane write enables; bit n enables byte n.
- `dmem_addr` in 32 — data address.
- `dmem_w_data` in 32 — write data, already lane-aligned by the core.
- `dmem_r_data` out 32 — read data (full word), registered.
- `gpio_in` in GPIO_W — asynchronous board inputs.
- `gpio_out` out GPIO_W — board outputs.
- `intrpt` out 1 — timer interrupt level, connects to the core's `intrpt`.
- `bus_err` out 1 — sticky flag for an out-of-range data access.

## Operation
- **RAM decode:** a data access hits RAM when `dmem_addr < MEM_WORDS*4`. The word index is `addr[log2(MEM_WORDS)+1:2]`, and `addr[1:0]` is ignored. Instruction fetch always indexes RAM with `imem_addr` bits taken modulo the RAM size.
- **RAM writes:** on `dmem_w_en`, only the byte lanes with a strobe bit set are updated.
- **RAM read ordering:** the fetch port and the data-read path both read before write. A same-word read and write in the same cycle returns the old word.
- **Read and write together:** if `dmem_r_en` and `dmem_w_en` are asserted in the same cycle, the write is performed and `dmem_r_data` returns the pre-write contents.
- **MMIO decode:** an access is MMIO when `addr[31:6] == MMIO_BASE[31:6]`. The register is selected by `addr[5:2]`.
  - 0x00 GPIO_IN, read-only: the 2-flop-synchronized `gpio_in`, zero-extended.
  - 0x04 GPIO_OUT, read-write: per-lane strobes apply; drives `gpio_out`.
  - 0x08 TMR_CNT, read-only: the live counter value.
  - 0x0C TMR_CMP, read-write: per-lane strobes apply.
  - 0x10 TMR_CTRL: bit0 EN (read-write). bit1 PEND (reads the pending flag; writing 1 clears it; writing 0 has no effect). Other bits read as 0.
  - 0x14 ERR_ADDR, read-only: the first faulting address.
  - Other offsets read 0 and ignore writes.
- **Timer:**
  - While EN=1, TMR_CNT increments each cycle.
  - When TMR_CNT == TMR_CMP with EN=1, the next count is 0 and PEND is set.
  - While EN=0, the count holds.
  - `intrpt` = PEND & EN.
  - If a match and a W1C clear of PEND occur in the same cycle, set wins.
  - A write to TMR_CMP takes effect for the compare on the following cycle.
- **Out-of-range access:** an address that is neither RAM nor MMIO causes:
  - the write to be dropped;
  - the read to return 32'hDEAD_BEEF;
  - `bus_err` to set, sticky until reset;
  - ERR_ADDR to capture the address only on the first error.
- **Fetch port range:** the fetch port never flags errors.

## Timing
- **Reset values:** `imem_r_data`=0, `dmem_r_data`=0, `gpio_out`=0, `intrpt`=0, `bus_err`=0. TMR_CNT, TMR_CMP, TMR_CTRL and ERR_ADDR reset to 0, and the GPIO synchronizers reset to 0.
- **RAM contents:** not reset.
- **Reset mid-access:** a write in the reset cycle is not performed.
- **Fetch latency:** `imem_addr` sampled at edge N produces `imem_r_data` valid after edge N, i.e. one cycle.
- **Data-read latency:** `dmem_addr` with `dmem_r_en` sampled at edge N produces `dmem_r_data` valid after edge N and held until the next read. This matches the core's EXEC→WR_BK flow.
- **Write commit:** writes commit at the sampling edge and are visible to any read sampled one edge later.
- **GPIO_IN latency:** 2 cycles of sync, plus 1 cycle of read latency.
- **Timer match timing:** with CMP=k, EN set at edge 0 and CNT=0, PEND rises after edge k+1, then every k+1 cycles after that.
- **Counter wrap:** with CMP=0xFFFF_FFFF the counter matches at all-ones and restarts at 0. With CMP=0 and EN=1, PEND sets every cycle.
- **Read-during-write of MMIO:** returns the pre-write value.

## Test plan
- **Byte-lane write:** write 32'hAABBCCDD to addr 0x100 with strb 4'b1111, then strb 4'b0010 with data 32'h0000_1100. Read 0x100 → 32'hAABB11DD, returned one cycle after the request.
- **Dual port:** fetch addr 0x100 while writing 0x100 in the same cycle. `imem_r_data` returns the old word and the next fetch returns the new word. A simultaneous r_en+w_en returns the pre-write data.
- **Timer:** CMP=3, EN=1. `intrpt` rises 4 cycles later. W1C to PEND drops `intrpt` the next cycle, and it re-asserts 4 cycles after the previous match. A clear coincident with a match leaves PEND=1.
- **GPIO:** `gpio_in`=16'h5A5A. A read of MMIO_BASE+0 issued 2 cycles later returns 32'h0000_5A5A. A write of 32'h1234 with strb 4'b0001 to +4 gives `gpio_out`=16'h0034.
- **Bus error:** a read at 0x2000_0000 returns 32'hDEAD_BEEF and sets `bus_err`. A later faulting write at 0x3000_0000 is dropped and ERR_ADDR still reads 32'h2000_0000.
- **Reset mid-operation:** assert `rst` while the timer is running and a write is pending. Every output, CNT, CTRL and `bus_err` read 0, and the write is not committed.
